bf_coef_bank: RTL

//  Double-buffered weight store directly upstream of BeamFormer_n; drives its argsB input.

---
 rtl/crpa_bf_pkg.sv | 13 +
 rtl/bf_coef_bank.sv | 130 +++++++++++++
 2 files changed

// File: rtl/crpa_bf_pkg.sv
// rtl/crpa_bf_pkg.sv - shared beamformer weight constants and coefficient bank state type
package crpa_bf_pkg;

    localparam int BF_NN       = 4;
    localparam int BF_B_WIDTH  = 16;
    localparam int BF_RST_GAIN = 2 ** (BF_B_WIDTH - 2);

    typedef enum logic {
        LOAD = 1'b0,
        PEND = 1'b1
    } bf_bank_state_e;

endpackage

// File: rtl/bf_coef_bank.sv
// rtl/bf_coef_bank.sv - double-buffered beamformer weight bank, swapped on epoch strobe
module bf_coef_bank
    import crpa_bf_pkg::*;
#(
    parameter int NN       = BF_NN,
    parameter int B_WIDTH  = BF_B_WIDTH,
    parameter int REF_CH   = 0,
    parameter int RST_GAIN = 2 ** (B_WIDTH - 2)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [B_WIDTH-1:0]      s_data,
    input  logic                    s_last,
    input  logic                    epoch,
    input  logic                    flush,
    input  logic                    clr_err,
    output logic [NN*B_WIDTH-1:0]   coefs_out,
    output logic                    coef_upd,
    output logic                    pending,
    output logic                    err_len,
    output logic [7:0]              upd_cnt
);

    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [B_WIDTH-1:0] GAIN_W = B_WIDTH'(RST_GAIN);
    localparam logic [NN*B_WIDTH-1:0] RST_COEFS =
        (NN*B_WIDTH)'(GAIN_W) << (REF_CH * B_WIDTH);

    bf_bank_state_e          state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [B_WIDTH-1:0]      shadow_q [NN];
    logic [B_WIDTH-1:0]      shadow_d [NN];
    logic [NN*B_WIDTH-1:0]   coefs_q, coefs_d;
    logic                    coef_upd_q, coef_upd_d;
    logic                    err_len_q, err_len_d;
    logic [7:0]              upd_cnt_q, upd_cnt_d;
    logic                    err_set;

    assign s_ready   = (state_q == LOAD);
    assign pending   = (state_q == PEND);
    assign coefs_out = coefs_q;
    assign coef_upd  = coef_upd_q;
    assign err_len   = err_len_q;
    assign upd_cnt   = upd_cnt_q;

    // Next-state: burst capture into shadow, epoch-gated promotion, flush abort, sticky length error
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        coefs_d    = coefs_q;
        coef_upd_d = 1'b0;
        err_len_d  = err_len_q;
        upd_cnt_d  = upd_cnt_q;
        err_set    = 1'b0;

        if (flush) begin
            // Flush wins over both a concurrent beat and a concurrent epoch.
            idx_d   = '0;
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    if (s_valid) begin
                        shadow_d[idx_q] = s_data;
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            if (s_last) begin
                                state_d = PEND;
                            end else begin
                                err_set = 1'b1;
                            end
                        end else if (s_last) begin
                            idx_d   = '0;
                            err_set = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (epoch) begin
                        for (int k = 0; k < NN; k++) begin
                            coefs_d[k*B_WIDTH +: B_WIDTH] = shadow_q[k];
                        end
                        coef_upd_d = 1'b1;
                        upd_cnt_d  = upd_cnt_q + 8'd1;
                        state_d    = LOAD;
                    end
                end
                default: state_d = LOAD;
            endcase
        end

        // A fresh error in the same cycle as a clear keeps the flag set.
        if (clr_err) begin
            err_len_d = 1'b0;
        end
        if (err_set) begin
            err_len_d = 1'b1;
        end
    end

    // State registers with asynchronous return to the reset weight set
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            for (int k = 0; k < NN; k++) begin
                shadow_q[k] <= '0;
            end
            coefs_q    <= RST_COEFS;
            coef_upd_q <= 1'b0;
            err_len_q  <= 1'b0;
            upd_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            coefs_q    <= coefs_d;
            coef_upd_q <= coef_upd_d;
            err_len_q  <= err_len_d;
            upd_cnt_q  <= upd_cnt_d;
        end
    end

endmodule
